// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU memory path: RAM handshake status, responder
// state encoding and the machine word.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    DONE = 2'd3
  } mresp_state_t;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/access_timer.sv
// Per-access cycle counter; done flags the last allowed cycle (TIMEOUT-1)
// so the responder can force completion on that edge.
module access_timer
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // Saturates at LAST so the count can never wrap inside one access.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count_reg != LAST)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign done = (count_reg == LAST);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates fetch and data requests (data first) onto
// one RAM port, runs the RAM handshake and returns one-cycle hit pulses.
module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              merr,
  output logic              busy,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  mresp_state_t state_reg, state_next;
  logic              ramren_reg, ramren_next;
  logic              ramwen_reg, ramwen_next;
  logic [ADDR_W-1:0] ramaddr_reg, ramaddr_next;
  logic [DATA_W-1:0] ramstore_reg, ramstore_next;
  logic [DATA_W-1:0] iload_reg, iload_next;
  logic [DATA_W-1:0] dload_reg, dload_next;
  logic              ihit_reg, ihit_next;
  logic              dhit_reg, dhit_next;
  logic              merr_reg, merr_next;
  logic              busy_reg, busy_next;

  logic      timer_clear;
  logic      timer_enable;
  logic      timer_done;
  ramstate_t ram_st;

  assign ram_st = ramstate_t'(ramstate);

  access_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (timer_clear),
    .enable (timer_enable),
    .done   (timer_done)
  );

  always_comb begin
    state_next    = state_reg;
    ramren_next   = ramren_reg;
    ramwen_next   = ramwen_reg;
    ramaddr_next  = ramaddr_reg;
    ramstore_next = ramstore_reg;
    iload_next    = iload_reg;
    dload_next    = dload_reg;
    ihit_next     = 1'b0;
    dhit_next     = 1'b0;
    merr_next     = 1'b0;
    timer_clear   = 1'b1;
    timer_enable  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (dWEN || dREN) begin
          state_next    = DACC;
          ramwen_next   = dWEN;
          ramren_next   = !dWEN;
          ramaddr_next  = daddr;
          ramstore_next = dstore;
        end else if (iREN) begin
          state_next   = IACC;
          ramren_next  = 1'b1;
          ramwen_next  = 1'b0;
          ramaddr_next = iaddr;
        end
      end

      DACC, IACC: begin
        timer_clear  = 1'b0;
        timer_enable = 1'b1;
        // ACCESS is tested first so a coinciding timeout still counts as success.
        if (ram_st == ACCESS || ram_st == ERROR || timer_done) begin
          state_next  = DONE;
          ramren_next = 1'b0;
          ramwen_next = 1'b0;
          ihit_next   = (state_reg == IACC);
          dhit_next   = (state_reg == DACC);
          merr_next   = (ram_st != ACCESS);
          if (ram_st == ACCESS && ramren_reg) begin
            if (state_reg == IACC) begin
              iload_next = ramload;
            end else begin
              dload_next = ramload;
            end
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      ramren_reg   <= 1'b0;
      ramwen_reg   <= 1'b0;
      ramaddr_reg  <= '0;
      ramstore_reg <= '0;
      iload_reg    <= '0;
      dload_reg    <= '0;
      ihit_reg     <= 1'b0;
      dhit_reg     <= 1'b0;
      merr_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ramren_reg   <= ramren_next;
      ramwen_reg   <= ramwen_next;
      ramaddr_reg  <= ramaddr_next;
      ramstore_reg <= ramstore_next;
      iload_reg    <= iload_next;
      dload_reg    <= dload_next;
      ihit_reg     <= ihit_next;
      dhit_reg     <= dhit_next;
      merr_reg     <= merr_next;
      busy_reg     <= busy_next;
    end
  end

  assign ramREN   = ramren_reg;
  assign ramWEN   = ramwen_reg;
  assign ramaddr  = ramaddr_reg;
  assign ramstore = ramstore_reg;
  assign iload    = iload_reg;
  assign dload    = dload_reg;
  assign ihit     = ihit_reg;
  assign dhit     = dhit_reg;
  assign merr     = merr_reg;
  assign busy     = busy_reg;

endmodule
